// File: rtl/control_sequencer_if.sv
// Strobe/handshake bundle between the hardwired control sequencer and the single-bus datapath.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;

  logic        PCout;
  logic        IncPC;
  logic        MARin;
  logic        Zin;
  logic        PCin;
  logic        Zlowout;
  logic        ZHighout;
  logic        Read;
  logic        MDRin;
  logic        MDRout;
  logic        IRin;
  logic        Yin;
  logic        Rout;
  logic        Rin;
  logic [3:0]  rsel;
  logic        HIin;
  logic        LOin;
  logic [3:0]  alu_op;
  logic        halted;
  logic        illegal;

  modport master (
    input  run, ir, mem_ready,
    output PCout, IncPC, MARin, Zin, PCin, Zlowout, ZHighout, Read, MDRin, MDRout, IRin, Yin,
           Rout, Rin, rsel, HIin, LOin, alu_op, halted, illegal
  );

  modport slave (
    output run, ir, mem_ready,
    input  PCout, IncPC, MARin, Zin, PCin, Zlowout, ZHighout, Read, MDRin, MDRout, IRin, Yin,
           Rout, Rin, rsel, HIin, LOin, alu_op, halted, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the single-bus CPU (T0-T6, HALT, illegal trap).
// Define MULDIV_EN to decode MUL/DIV with the two-cycle LO/HI writeback (T5/T6).
module control_sequencer (
  input logic                 clock,
  input logic                 clear,
  control_sequencer_if.master bus
);

`ifdef MULDIV_EN
  localparam bit MulDivEn = 1'b1;
`else
  localparam bit MulDivEn = 1'b0;
`endif

  localparam logic [4:0] OpMul  = 5'b01000;
  localparam logic [4:0] OpDiv  = 5'b01001;
  localparam logic [4:0] OpNeg  = 5'b01010;
  localparam logic [4:0] OpNot  = 5'b01011;
  localparam logic [4:0] OpHalt = 5'b11111;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
  } state_e;

  typedef struct packed {
    logic pc_out;
    logic inc_pc;
    logic mar_in;
    logic z_in;
    logic pc_in;
    logic z_low_out;
    logic z_high_out;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic r_out;
    logic r_in;
    logic hi_in;
    logic lo_in;
    logic halted;
    logic illegal;
  } strobe_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return MulDivEn && ((op == OpMul) || (op == OpDiv));
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return (op < OpMul) || (op == OpNeg) || (op == OpNot) || is_muldiv(op);
  endfunction

  state_e     state_q, state_d;
  logic [4:0] opcode_q, opcode_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic [3:0] rc_q, rc_d;
  strobe_t    strb_q, strb_d;
  logic [3:0] rsel_q, rsel_d;
  logic [3:0] alu_op_q, alu_op_d;

  logic unused_ir;
  assign unused_ir = ^bus.ir[14:0];

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    case (state_q)
      StIdle: if (bus.run) state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   if (bus.mem_ready) state_d = StT2;
      StT2: begin
        opcode_d = bus.ir[31:27];
        ra_d     = bus.ir[26:23];
        rb_d     = bus.ir[22:19];
        rc_d     = bus.ir[18:15];
        state_d  = (bus.ir[31:27] == OpHalt) ? StHalt : StT3;
      end
      StT3: begin
        if (is_legal(opcode_q)) state_d = StT4;
        else                    state_d = bus.run ? StT0 : StIdle;
      end
      StT4: state_d = StT5;
      StT5: begin
        if (is_muldiv(opcode_q)) state_d = StT6;
        else                     state_d = bus.run ? StT0 : StIdle;
      end
      StT6:    state_d = bus.run ? StT0 : StIdle;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the state being entered and then registered, so each output
  // is a pure function of the registered state with no path from run/mem_ready.
  always_comb begin
    strb_d   = '0;
    rsel_d   = '0;
    alu_op_d = '0;
    case (state_d)
      StT0: begin
        strb_d.pc_out = 1'b1;
        strb_d.inc_pc = 1'b1;
        strb_d.mar_in = 1'b1;
        strb_d.z_in   = 1'b1;
        alu_op_d      = 4'hF;
      end
      StT1: begin
        strb_d.z_low_out = 1'b1;
        strb_d.pc_in     = 1'b1;
        strb_d.read      = 1'b1;
        strb_d.mdr_in    = 1'b1;
      end
      StT2: begin
        strb_d.mdr_out = 1'b1;
        strb_d.ir_in   = 1'b1;
      end
      StT3: begin
        if (is_legal(opcode_d)) begin
          strb_d.r_out = 1'b1;
          strb_d.y_in  = 1'b1;
          rsel_d       = rb_d;
        end else begin
          strb_d.illegal = 1'b1;
        end
      end
      StT4: begin
        strb_d.r_out = 1'b1;
        strb_d.z_in  = 1'b1;
        alu_op_d     = opcode_d[3:0];
        rsel_d       = ((opcode_d == OpNeg) || (opcode_d == OpNot)) ? rb_d : rc_d;
      end
      StT5: begin
        strb_d.z_low_out = 1'b1;
        if (is_muldiv(opcode_d)) begin
          strb_d.lo_in = 1'b1;
        end else begin
          strb_d.r_in = 1'b1;
          rsel_d      = ra_d;
        end
      end
      StT6: begin
        strb_d.z_high_out = 1'b1;
        strb_d.hi_in      = MulDivEn;
      end
      StHalt:  strb_d.halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      strb_q   <= '0;
      rsel_q   <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      strb_q   <= strb_d;
      rsel_q   <= rsel_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign bus.PCout    = strb_q.pc_out;
  assign bus.IncPC    = strb_q.inc_pc;
  assign bus.MARin    = strb_q.mar_in;
  assign bus.Zin      = strb_q.z_in;
  assign bus.PCin     = strb_q.pc_in;
  assign bus.Zlowout  = strb_q.z_low_out;
  assign bus.ZHighout = strb_q.z_high_out;
  assign bus.Read     = strb_q.read;
  assign bus.MDRin    = strb_q.mdr_in;
  assign bus.MDRout   = strb_q.mdr_out;
  assign bus.IRin     = strb_q.ir_in;
  assign bus.Yin      = strb_q.y_in;
  assign bus.Rout     = strb_q.r_out;
  assign bus.Rin      = strb_q.r_in;
  assign bus.rsel     = rsel_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.halted   = strb_q.halted;
  assign bus.illegal  = strb_q.illegal;

`ifdef MULDIV_EN
  assign bus.HIin = strb_q.hi_in;
  assign bus.LOin = strb_q.lo_in;
`else
  assign bus.HIin = 1'b0;
  assign bus.LOin = 1'b0;
  logic unused_hilo;
  assign unused_hilo = strb_q.hi_in ^ strb_q.lo_in;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer plus hand sequences for MUL/DIV, async clear
// and a randomized single-bus-driver sweep.
module tb_control_sequencer;
  logic clock = 1'b0;
  logic clear;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  localparam logic [17:0] PCOUT = 18'h20000, INCPC = 18'h10000, MARIN = 18'h08000;
  localparam logic [17:0] ZIN   = 18'h04000, PCIN  = 18'h02000, ZLOW  = 18'h01000;
  localparam logic [17:0] ZHIGH = 18'h00800, READ  = 18'h00400, MDRIN = 18'h00200;
  localparam logic [17:0] MDROUT = 18'h00100, IRIN = 18'h00080, YIN   = 18'h00040;
  localparam logic [17:0] ROUT  = 18'h00020, RIN   = 18'h00010, HIIN  = 18'h00008;
  localparam logic [17:0] LOIN  = 18'h00004, HALTD = 18'h00002, ILL   = 18'h00001;

  localparam logic [17:0] T0S = PCOUT | INCPC | MARIN | ZIN;
  localparam logic [17:0] T1S = ZLOW | PCIN | READ | MDRIN;
  localparam logic [17:0] T2S = MDROUT | IRIN;

  localparam logic [31:0] AND_IR  = 32'h10918000;             // AND R1,R2,R3
  localparam logic [31:0] NEG_IR  = {5'b01010, 4'd7, 4'd8, 4'd0, 15'd0};
  localparam logic [31:0] ILL_IR  = {5'b10101, 4'd1, 4'd2, 4'd3, 15'd0};
  localparam logic [31:0] HALT_IR = 32'hF8000000;
  localparam logic [31:0] MUL_IR  = {5'b01000, 4'd0, 4'd2, 4'd3, 15'd0};

  wire [17:0] act_st = {bus.PCout, bus.IncPC, bus.MARin, bus.Zin, bus.PCin, bus.Zlowout,
                        bus.ZHighout, bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin,
                        bus.Rout, bus.Rin, bus.HIin, bus.LOin, bus.halted, bus.illegal};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] ir;
    logic        run;
    logic        mr;
    logic [17:0] st;
    logic [3:0]  rs;
    logic [3:0]  alu;
  } vec_t;

  vec_t tbl[27];

  task automatic check(input string name, input logic [17:0] st, input logic [3:0] rs,
                       input logic [3:0] alu);
    logic ok;
    total++;
    ok = (act_st === st);
    if (((st & (ROUT | RIN)) != 0) && (bus.rsel !== rs)) ok = 1'b0;
    if (((st & ZIN) != 0) && (bus.alu_op !== alu)) ok = 1'b0;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got st=%h rsel=%h alu=%h, want st=%h rsel=%h alu=%h",
               name, act_st, bus.rsel, bus.alu_op, st, rs, alu);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.run       = 1'b0;
    bus.mem_ready = 1'b1;
    bus.ir        = '0;
    clear         = 1'b0;
    #3;
    clear = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Rows are applied before a rising edge; expectations are the state entered at that edge.
    tbl[0]  = '{AND_IR,  1'b1, 1'b1, T0S,          4'd0, 4'hF};
    tbl[1]  = '{AND_IR,  1'b1, 1'b1, T1S,          4'd0, 4'd0};
    tbl[2]  = '{AND_IR,  1'b1, 1'b1, T2S,          4'd0, 4'd0};
    tbl[3]  = '{AND_IR,  1'b1, 1'b1, ROUT | YIN,   4'd2, 4'd0};
    tbl[4]  = '{AND_IR,  1'b1, 1'b1, ROUT | ZIN,   4'd3, 4'd2};
    tbl[5]  = '{AND_IR,  1'b1, 1'b1, ZLOW | RIN,   4'd1, 4'd0};
    tbl[6]  = '{NEG_IR,  1'b1, 1'b1, T0S,          4'd0, 4'hF};
    tbl[7]  = '{NEG_IR,  1'b1, 1'b0, T1S,          4'd0, 4'd0};
    tbl[8]  = '{NEG_IR,  1'b1, 1'b0, T1S,          4'd0, 4'd0};
    tbl[9]  = '{NEG_IR,  1'b1, 1'b0, T1S,          4'd0, 4'd0};
    tbl[10] = '{NEG_IR,  1'b1, 1'b0, T1S,          4'd0, 4'd0};
    tbl[11] = '{NEG_IR,  1'b1, 1'b1, T2S,          4'd0, 4'd0};
    tbl[12] = '{NEG_IR,  1'b0, 1'b0, ROUT | YIN,   4'd8, 4'd0};
    tbl[13] = '{NEG_IR,  1'b0, 1'b0, ROUT | ZIN,   4'd8, 4'hA};
    tbl[14] = '{NEG_IR,  1'b0, 1'b0, ZLOW | RIN,   4'd7, 4'd0};
    tbl[15] = '{NEG_IR,  1'b0, 1'b1, 18'd0,        4'd0, 4'd0};
    tbl[16] = '{NEG_IR,  1'b0, 1'b1, 18'd0,        4'd0, 4'd0};
    tbl[17] = '{ILL_IR,  1'b1, 1'b1, T0S,          4'd0, 4'hF};
    tbl[18] = '{ILL_IR,  1'b1, 1'b1, T1S,          4'd0, 4'd0};
    tbl[19] = '{ILL_IR,  1'b1, 1'b1, T2S,          4'd0, 4'd0};
    tbl[20] = '{ILL_IR,  1'b1, 1'b1, ILL,          4'd0, 4'd0};
    tbl[21] = '{HALT_IR, 1'b1, 1'b1, T0S,          4'd0, 4'hF};
    tbl[22] = '{HALT_IR, 1'b1, 1'b1, T1S,          4'd0, 4'd0};
    tbl[23] = '{HALT_IR, 1'b1, 1'b1, T2S,          4'd0, 4'd0};
    tbl[24] = '{HALT_IR, 1'b1, 1'b1, HALTD,        4'd0, 4'd0};
    tbl[25] = '{HALT_IR, 1'b1, 1'b1, HALTD,        4'd0, 4'd0};
    tbl[26] = '{HALT_IR, 1'b0, 1'b1, HALTD,        4'd0, 4'd0};

    // Reset and idle hold
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ir        = '0;
    clear         = 1'b0;
    #12;
    check("reset", 18'd0, 4'd0, 4'd0);
    if (bus.rsel !== 4'd0 || bus.alu_op !== 4'd0) begin
      bad++;
      $display("FAIL reset_fields: got rsel=%h alu=%h, want 0 0", bus.rsel, bus.alu_op);
    end
    total++;
    #2;
    clear = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("idle%0d", i), 18'd0, 4'd0, 4'd0);
    end

    for (int i = 0; i < 27; i++) begin
      bus.ir        = tbl[i].ir;
      bus.run       = tbl[i].run;
      bus.mem_ready = tbl[i].mr;
      step();
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].rs, tbl[i].alu);
    end

    // MUL R2,R3
    do_reset();
    bus.ir  = MUL_IR;
    bus.run = 1'b1;
    step(); check("mul_t0", T0S, 4'd0, 4'hF);
    step(); check("mul_t1", T1S, 4'd0, 4'd0);
    step(); check("mul_t2", T2S, 4'd0, 4'd0);
`ifdef MULDIV_EN
    step(); check("mul_t3", ROUT | YIN, 4'd2, 4'd0);
    bus.run = 1'b0;
    step(); check("mul_t4", ROUT | ZIN, 4'd3, 4'd8);
    step(); check("mul_t5", ZLOW | LOIN, 4'd0, 4'd0);
    step(); check("mul_t6", ZHIGH | HIIN, 4'd0, 4'd0);
    step(); check("mul_end", 18'd0, 4'd0, 4'd0);
`else
    step(); check("mul_ill", ILL, 4'd0, 4'd0);
    bus.run = 1'b0;
    step(); check("mul_end", 18'd0, 4'd0, 4'd0);
    step(); check("mul_idle", 18'd0, 4'd0, 4'd0);
`endif

    // Asynchronous clear in T4
    do_reset();
    bus.ir  = AND_IR;
    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("pre_clr_t4", ROUT | ZIN, 4'd3, 4'd2);
    #2;
    clear = 1'b0;
    #1;
    check("async_clr", 18'd0, 4'd0, 4'd0);
    bus.run = 1'b0;
    clear   = 1'b1;
    step(); check("post_clr", 18'd0, 4'd0, 4'd0);

    // Randomized single-bus-driver sweep
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] op;
      int drivers;
      op = 5'($urandom_range(0, 30));
      bus.ir        = {op, 27'($urandom)};
      bus.run       = ($urandom_range(0, 7) != 0);
      bus.mem_ready = $urandom_range(0, 1) == 1;
      step();
      drivers = int'(bus.PCout) + int'(bus.Zlowout) + int'(bus.ZHighout) + int'(bus.MDRout) +
                int'(bus.Rout);
      total++;
      if (drivers > 1) begin
        bad++;
        $display("FAIL bus_invariant cycle %0d: got drivers=%0d, want <=1", i, drivers);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
